spb_arb: RTL and testbench
==========================

Name: spb_arb

Overview:
- Two-master to one-slave arbiter for the SPB bus. Sits directly upstream of the SPB address decoder; its M port drives the decoder's slave port.
- S0 is the instruction-fetch master and S1 is the load/store master.
- Provides round-robin arbitration with a registered grant, holds the grant for a whole transfer, and aborts any transfer the slave never completes.

Parameters:
TMO_W, 8, width of the timeout counter
TMO_CYC, 255, granted cycles without M_SPB_READY before abort; 0 disables the timeout (must fit in TMO_W)

Ports:
CLK  in  1  clock; all state changes on the rising edge
RST  in  1  asynchronous active-high reset
S0_SPB_VALID  in  1  master 0 request
S0_SPB_WSTB  in  4  master 0 byte strobes; 0 = read
S0_SPB_ADDR  in  32  master 0 address
S0_SPB_WDATA  in  32  master 0 write data
S0_SPB_READY  out  1  master 0 transfer complete
S0_SPB_RDATA  out  32  master 0 read data
S0_SPB_EXCPT  out  1  master 0 exception
S1_SPB_* (VALID, WSTB, ADDR, WDATA, READY, RDATA, EXCPT)  same widths and directions as S0, for master 1
M_SPB_VALID  out  1  request to the decoder
M_SPB_WSTB  out  4  forwarded strobes
M_SPB_ADDR  out  32  forwarded address
M_SPB_WDATA  out  32  forwarded write data
M_SPB_READY  in  1  decoder completion
M_SPB_RDATA  in  32  decoder read data
M_SPB_EXCPT  in  1  decoder exception
TMO  out  1  one-cycle pulse on timeout abort

Behaviour:
- SPB protocol:
  - A master holds VALID, ADDR, WSTB and WDATA stable until it sees READY=1.
  - READY, RDATA and EXCPT are valid only in the READY cycle.
- States: IDLE, GNT0, GNT1. Registers: state, last (index of the last granted port), cnt[TMO_W-1:0].
- Reset values (RST=1): state=IDLE, last=1 (so S0 wins the first tie), cnt=0.
  - All outputs are combinational from state and inputs. In IDLE: M_SPB_VALID=0, M_SPB_WSTB/ADDR/WDATA=0, all S*_READY=0, all S*_EXCPT=0, all S*_RDATA=0, TMO=0.
- IDLE transitions:
  - Only S0_VALID=1 -> GNT0.
  - Only S1_VALID=1 -> GNT1.
  - Both=1 -> grant the port != last.
  - Neither -> stay in IDLE.
  - Entering any GNTx: cnt<=0 and last<=x.
  - The grant is registered, so a request is never forwarded in the cycle it first appears. Minimum latency is 1 cycle from VALID to M_SPB_VALID.
- GNTx forwarding:
  - M_SPB_VALID=Sx_VALID, with Sx WSTB/ADDR/WDATA passed through unchanged.
  - Sx_READY=M_SPB_READY, Sx_RDATA=M_SPB_RDATA, Sx_EXCPT=M_SPB_EXCPT.
  - The non-granted port sees READY=0, RDATA=0, EXCPT=0.
- Completion (GNTx, M_SPB_READY=1):
  - If the other port's VALID=1 -> go to GNT(other), with cnt<=0 and last<=other.
  - Else -> IDLE.
  - Outcome: alternating masters stream back-to-back; one master alone gets at most one transfer per 2 cycles.
- Timeout:
  - In GNTx with M_SPB_READY=0 and TMO_CYC!=0, cnt increments.
  - When cnt==TMO_CYC and M_SPB_READY=0, the abort cycle applies: M_SPB_VALID=0, Sx_READY=1, Sx_EXCPT=1, Sx_RDATA=0, TMO=1. Next state follows the completion rule.
  - Abort therefore happens on the (TMO_CYC+1)-th granted cycle.
  - M_SPB_READY=1 in the same cycle that cnt==TMO_CYC wins: the transfer completes normally and TMO=0.
- Protocol violation: Sx_VALID drops in GNTx without READY -> IDLE on the next edge, no response, cnt ignored.
- Reset mid-transfer: asynchronous return to IDLE. M_SPB_VALID falls immediately, with no response to the master.
- M_SPB_EXCPT is forwarded unchanged and does not affect state beyond normal completion.

Test Plan:
- Single read: S0_VALID, ADDR=0x0000_0100, WSTB=0; the slave returns READY on the first M cycle with RDATA=0xDEADBEEF -> M_SPB_VALID high in cycle 1 only; S0_READY=1 with RDATA=0xDEADBEEF in cycle 1; state back to IDLE in cycle 2.
- Tie after reset: both VALID in cycle 0 -> S0 granted first. On its completion, S1 is granted the next cycle with no IDLE gap. S1 ADDR=0x4000_0004, WSTB=0xF, WDATA=0x12345678 appear unchanged on M.
- Fairness: both masters continuously requesting, slave always ready -> grants alternate S0,S1,S0,S1 and each S port sees READY every 2nd cycle.
- Wait states: slave holds READY=0 for 3 cycles -> grant held, ADDR stable, S1 ignored; on READY the S port gets data and EXCPT=M_SPB_EXCPT.
- Timeout: TMO_CYC=4, slave never ready -> cycle 5 of the grant gives S0_READY=1, S0_EXCPT=1, RDATA=0, TMO=1, M_SPB_VALID=0; with TMO_CYC=0 the grant persists indefinitely.
- Reset mid-grant: RST pulsed while in GNT1 -> M_SPB_VALID=0 asynchronously; after release with both requesting, S0 is granted first.

Source files
------------

// File: rtl/spb_arb_if.sv
// SPB bus bundle shared by both arbiter upstream ports and the downstream port.
//   valid/wstb/addr/wdata : request, driven by the requesting side
//   ready/rdata/excpt     : response, driven by the completing side
// modport master : the side that issues requests (a CPU master, or the arbiter's M port)
// modport slave  : the side that answers requests (the decoder, or the arbiter's S ports)
interface spb_arb_if;
    logic        valid;
    logic [3:0]  wstb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        excpt;

    modport master (
        output valid, wstb, addr, wdata,
        input  ready, rdata, excpt
    );

    modport slave (
        input  valid, wstb, addr, wdata,
        output ready, rdata, excpt
    );
endinterface

// File: rtl/spb_arb.sv
// Two-master to one-slave round-robin arbiter for the SPB bus.
// S0 is the instruction-fetch master, S1 the load/store master; M drives the
// address decoder. The grant is registered and held for a whole transfer;
// a transfer the slave never completes is aborted after TMO_CYC waiting cycles.
//   CLK : clock, all state changes on the rising edge
//   RST : asynchronous active-high reset
//   s0  : master 0 port (slave modport)
//   s1  : master 1 port (slave modport)
//   m   : port to the decoder (master modport)
//   TMO : one-cycle pulse in the cycle a transfer is aborted
//
// state | meaning
// IDLE  | no grant; all outputs zero
// GNT0  | S0 owns M; request forwarded, response routed to S0
// GNT1  | S1 owns M; request forwarded, response routed to S1
module spb_arb #(
    parameter int TMO_W   = 8,
    parameter int TMO_CYC = 255
) (
    input  logic       CLK,
    input  logic       RST,
    spb_arb_if.slave   s0,
    spb_arb_if.slave   s1,
    spb_arb_if.master  m,
    output logic       TMO
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_CYC);
    localparam bit               TMO_EN  = (TMO_CYC != 0);

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;

    logic        gnt;
    logic        gnt1;
    logic        req_valid;
    logic        other_valid;
    logic        abort;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_excpt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;

        m.valid     = 1'b0;
        m.wstb      = '0;
        m.addr      = '0;
        m.wdata     = '0;
        s0.ready    = 1'b0;
        s0.rdata    = '0;
        s0.excpt    = 1'b0;
        s1.ready    = 1'b0;
        s1.rdata    = '0;
        s1.excpt    = 1'b0;
        TMO         = 1'b0;

        gnt         = (state_q == GNT0) || (state_q == GNT1);
        gnt1        = (state_q == GNT1);
        req_valid   = gnt1 ? s1.valid : s0.valid;
        other_valid = gnt1 ? s0.valid : s1.valid;
        // A slave READY in the limit cycle takes precedence over the abort.
        abort       = gnt && TMO_EN && req_valid && !m.ready && (cnt_q == TMO_LIM);
        rsp_ready   = 1'b0;
        rsp_rdata   = '0;
        rsp_excpt   = 1'b0;

        case (state_q)
            IDLE: begin
                // last_q holds the previous winner, so a tie goes to the other port.
                if (s0.valid && (!s1.valid || last_q)) begin
                    state_d = GNT0;
                    last_d  = 1'b0;
                    cnt_d   = '0;
                end else if (s1.valid) begin
                    state_d = GNT1;
                    last_d  = 1'b1;
                    cnt_d   = '0;
                end
            end

            GNT0, GNT1: begin
                m.valid   = req_valid && !abort;
                m.wstb    = gnt1 ? s1.wstb  : s0.wstb;
                m.addr    = gnt1 ? s1.addr  : s0.addr;
                m.wdata   = gnt1 ? s1.wdata : s0.wdata;

                rsp_ready = abort ? 1'b1 : m.ready;
                rsp_rdata = abort ? '0   : m.rdata;
                rsp_excpt = abort ? 1'b1 : m.excpt;
                TMO       = abort;

                if (gnt1) begin
                    s1.ready = rsp_ready;
                    s1.rdata = rsp_rdata;
                    s1.excpt = rsp_excpt;
                end else begin
                    s0.ready = rsp_ready;
                    s0.rdata = rsp_rdata;
                    s0.excpt = rsp_excpt;
                end

                if (!req_valid) begin
                    // Master withdrew without a response: drop the grant silently.
                    state_d = IDLE;
                end else if (m.ready || abort) begin
                    if (other_valid) begin
                        state_d = gnt1 ? GNT0 : GNT1;
                        last_d  = !gnt1;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (TMO_EN) begin
                    cnt_d = cnt_q + TMO_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spb_arb.sv
module tb_spb_arb;

    logic clk;
    logic rst;
    logic tmo;
    logic clk_b_unused;
    logic tmo_b;

    int checks;
    int errors;

    spb_arb_if s0_if();
    spb_arb_if s1_if();
    spb_arb_if m_if();

    spb_arb_if s0b_if();
    spb_arb_if s1b_if();
    spb_arb_if mb_if();

    spb_arb #(.TMO_W(8), .TMO_CYC(4)) dut (
        .CLK (clk),
        .RST (rst),
        .s0  (s0_if),
        .s1  (s1_if),
        .m   (m_if),
        .TMO (tmo)
    );

    spb_arb #(.TMO_W(8), .TMO_CYC(0)) dut_notmo (
        .CLK (clk),
        .RST (rst),
        .s0  (s0b_if),
        .s1  (s1b_if),
        .m   (mb_if),
        .TMO (tmo_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        clk_b_unused = 1'b0;
        rst          = 1'b1;
        s0_if.valid = 0; s0_if.wstb = 0; s0_if.addr = 0; s0_if.wdata = 0;
        s1_if.valid = 0; s1_if.wstb = 0; s1_if.addr = 0; s1_if.wdata = 0;
        m_if.ready  = 0; m_if.rdata = 0; m_if.excpt = 0;
        s0b_if.valid = 0; s0b_if.wstb = 0; s0b_if.addr = 0; s0b_if.wdata = 0;
        s1b_if.valid = 0; s1b_if.wstb = 0; s1b_if.addr = 0; s1b_if.wdata = 0;
        mb_if.ready  = 0; mb_if.rdata = 0; mb_if.excpt = 0;

        // Reset: IDLE outputs stay zero even with live inputs.
        step(); step();
        s0_if.valid = 1; s0_if.addr = 32'h0000_0AAA;
        m_if.ready = 1; m_if.rdata = 32'hFFFF_FFFF; m_if.excpt = 1;
        #1;
        chk("rst_m_valid",  32'(m_if.valid), 32'd0);
        chk("rst_m_addr",   m_if.addr,       32'd0);
        chk("rst_s0_ready", 32'(s0_if.ready), 32'd0);
        chk("rst_s0_rdata", s0_if.rdata,     32'd0);
        chk("rst_s0_excpt", 32'(s0_if.excpt), 32'd0);
        chk("rst_tmo",      32'(tmo),        32'd0);
        s0_if.valid = 0; s0_if.addr = 0; m_if.excpt = 0;
        rst = 0;
        step();

        // Single read, slave ready on the first M cycle.
        s0_if.valid = 1; s0_if.addr = 32'h0000_0100; s0_if.wstb = 4'h0;
        m_if.ready = 1; m_if.rdata = 32'hDEAD_BEEF;
        #1;
        chk("rd_c0_m_valid", 32'(m_if.valid), 32'd0);
        step();
        chk("rd_c1_m_valid",  32'(m_if.valid), 32'd1);
        chk("rd_c1_m_addr",   m_if.addr,       32'h0000_0100);
        chk("rd_c1_s0_ready", 32'(s0_if.ready), 32'd1);
        chk("rd_c1_s0_rdata", s0_if.rdata,     32'hDEAD_BEEF);
        chk("rd_c1_s1_ready", 32'(s1_if.ready), 32'd0);
        step();
        s0_if.valid = 0;
        #1;
        chk("rd_c2_m_valid",  32'(m_if.valid), 32'd0);
        chk("rd_c2_s0_ready", 32'(s0_if.ready), 32'd0);

        // Tie after reset: S0 first, then S1 back-to-back.
        rst = 1; #1; rst = 0;
        s0_if.valid = 1; s0_if.addr = 32'h0000_0200; s0_if.wstb = 4'h0;
        s1_if.valid = 1; s1_if.addr = 32'h4000_0004; s1_if.wstb = 4'hF; s1_if.wdata = 32'h1234_5678;
        m_if.ready = 1; m_if.rdata = 32'h1111_1111;
        #1;
        chk("tie_c0_m_valid", 32'(m_if.valid), 32'd0);
        step();
        chk("tie_c1_m_addr",   m_if.addr,        32'h0000_0200);
        chk("tie_c1_s0_ready", 32'(s0_if.ready), 32'd1);
        chk("tie_c1_s1_ready", 32'(s1_if.ready), 32'd0);
        step();
        s0_if.valid = 0;
        #1;
        chk("tie_c2_m_valid",  32'(m_if.valid),  32'd1);
        chk("tie_c2_m_addr",   m_if.addr,        32'h4000_0004);
        chk("tie_c2_m_wstb",   32'(m_if.wstb),   32'hF);
        chk("tie_c2_m_wdata",  m_if.wdata,       32'h1234_5678);
        chk("tie_c2_s1_ready", 32'(s1_if.ready), 32'd1);
        chk("tie_c2_s0_ready", 32'(s0_if.ready), 32'd0);
        step();
        s1_if.valid = 0;
        #1;
        chk("tie_c3_m_valid", 32'(m_if.valid), 32'd0);

        // Fairness: both requesting continuously, slave always ready.
        s0_if.valid = 1; s0_if.addr = 32'hA000_0000; s0_if.wstb = 4'h0;
        s1_if.valid = 1; s1_if.addr = 32'hB000_0000; s1_if.wstb = 4'h0;
        m_if.ready = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fair_m_addr",   m_if.addr, (i % 2 == 0) ? 32'hA000_0000 : 32'hB000_0000);
            chk("fair_s0_ready", 32'(s0_if.ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("fair_s1_ready", 32'(s1_if.ready), (i % 2 == 0) ? 32'd0 : 32'd1);
        end
        s0_if.valid = 0; s1_if.valid = 0;
        step();
        chk("fair_end_m_valid", 32'(m_if.valid), 32'd0);

        // Wait states: grant held for 3 cycles while S1 also requests.
        s0_if.valid = 1; s0_if.addr = 32'h0000_0300;
        m_if.ready = 0; m_if.rdata = 32'h0;
        step();
        s1_if.valid = 1; s1_if.addr = 32'h0000_0600;
        for (int i = 1; i <= 3; i++) begin
            #1;
            chk("ws_m_addr",   m_if.addr,        32'h0000_0300);
            chk("ws_s0_ready", 32'(s0_if.ready), 32'd0);
            chk("ws_s1_ready", 32'(s1_if.ready), 32'd0);
            step();
        end
        m_if.ready = 1; m_if.rdata = 32'hCAFE_F00D; m_if.excpt = 1;
        #1;
        chk("ws_c4_s0_ready", 32'(s0_if.ready), 32'd1);
        chk("ws_c4_s0_rdata", s0_if.rdata,      32'hCAFE_F00D);
        chk("ws_c4_s0_excpt", 32'(s0_if.excpt), 32'd1);
        chk("ws_c4_tmo",      32'(tmo),         32'd0);
        step();
        s0_if.valid = 0; m_if.excpt = 0;
        #1;
        chk("ws_c5_m_addr",   m_if.addr,        32'h0000_0600);
        chk("ws_c5_s1_ready", 32'(s1_if.ready), 32'd1);
        chk("ws_c5_s1_excpt", 32'(s1_if.excpt), 32'd0);
        s1_if.valid = 0;
        step();
        chk("ws_end_m_valid", 32'(m_if.valid), 32'd0);

        // Timeout with TMO_CYC=4: abort on the 5th granted cycle.
        s0_if.valid = 1; s0_if.addr = 32'h0000_0500;
        m_if.ready = 0; m_if.rdata = 32'h5555_5555;
        step();
        for (int i = 1; i <= 4; i++) begin
            chk("to_wait_m_valid", 32'(m_if.valid), 32'd1);
            chk("to_wait_tmo",     32'(tmo),        32'd0);
            step();
        end
        chk("to_c5_s0_ready", 32'(s0_if.ready), 32'd1);
        chk("to_c5_s0_excpt", 32'(s0_if.excpt), 32'd1);
        chk("to_c5_s0_rdata", s0_if.rdata,      32'd0);
        chk("to_c5_tmo",      32'(tmo),         32'd1);
        chk("to_c5_m_valid",  32'(m_if.valid),  32'd0);
        step();
        s0_if.valid = 0;
        #1;
        chk("to_c6_m_valid", 32'(m_if.valid), 32'd0);
        chk("to_c6_tmo",     32'(tmo),        32'd0);

        // READY in the limit cycle wins over the abort.
        s0_if.valid = 1; s0_if.addr = 32'h0000_0700;
        step(); step(); step(); step(); step();
        m_if.ready = 1; m_if.rdata = 32'h0000_0077;
        #1;
        chk("tw_c5_tmo",      32'(tmo),         32'd0);
        chk("tw_c5_m_valid",  32'(m_if.valid),  32'd1);
        chk("tw_c5_s0_ready", 32'(s0_if.ready), 32'd1);
        chk("tw_c5_s0_excpt", 32'(s0_if.excpt), 32'd0);
        chk("tw_c5_s0_rdata", s0_if.rdata,      32'h0000_0077);
        step();
        s0_if.valid = 0; m_if.ready = 0;
        #1;
        chk("tw_c6_m_valid", 32'(m_if.valid), 32'd0);

        // TMO_CYC=0: grant persists indefinitely.
        s0b_if.valid = 1; s0b_if.addr = 32'h0000_0800;
        for (int i = 0; i < 300; i++) step();
        chk("nt_m_valid",  32'(mb_if.valid),  32'd1);
        chk("nt_m_addr",   mb_if.addr,        32'h0000_0800);
        chk("nt_s0_ready", 32'(s0b_if.ready), 32'd0);
        chk("nt_tmo",      32'(tmo_b),        32'd0);
        s0b_if.valid = 0;

        // Reset in the middle of a GNT1 transfer.
        s1_if.valid = 1; s1_if.addr = 32'h0000_0900;
        m_if.ready = 0;
        step();
        chk("rg_gnt1_m_valid", 32'(m_if.valid), 32'd1);
        chk("rg_gnt1_m_addr",  m_if.addr,       32'h0000_0900);
        rst = 1; m_if.ready = 1;
        #1;
        chk("rg_rst_m_valid",  32'(m_if.valid),  32'd0);
        chk("rg_rst_s1_ready", 32'(s1_if.ready), 32'd0);
        s0_if.valid = 1; s0_if.addr = 32'h0000_0A00;
        m_if.ready = 0;
        #1;
        rst = 0;
        step();
        chk("rg_post_m_addr",   m_if.addr,        32'h0000_0A00);
        chk("rg_post_s1_ready", 32'(s1_if.ready), 32'd0);
        s0_if.valid = 0; s1_if.valid = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
